mips_regfile_mp: RTL and testbench
==================================

Name: mips_regfile_mp

Overview:
- Parametrised multi-port register file for the single-cycle MIPS datapath and its planned wider variants.
- Configurable data width, depth, read-port count, two prioritised write ports, optional hardwired-zero register 0 and optional write-to-read bypass.
- A handshaked dump engine streams every register out sequentially for testbench and debug inspection. It replaces file-based state dumping.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes
- BYPASS, 0, 1 = a read of an address being written this cycle returns the write data

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port k occupies bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data; port k occupies bits [k*DATA_W +: DATA_W]
- we0  in  1  write enable, port 0
- wa0  in  ADDR_W  write address, port 0
- wd0  in  DATA_W  write data, port 0
- we1  in  1  write enable, port 1 (higher priority)
- wa1  in  ADDR_W  write address, port 1
- wd1  in  DATA_W  write data, port 1
- dump_start  in  1  request a full register dump
- dump_valid  out  1  dump beat valid
- dump_ready  in  1  consumer accepts beat
- dump_addr  out  ADDR_W  index of current beat
- dump_data  out  DATA_W  register contents for current beat
- dump_busy  out  1  dump engine not idle
- dump_done  out  1  one-cycle pulse after the last beat

Behaviour:
- Reset (async, rst=1):
  - All DEPTH registers clear to 0.
  - Dump FSM goes to IDLE.
  - dump_valid=0, dump_busy=0, dump_done=0, dump_addr=0, dump_data=0.
  - rd_data reflects the cleared array.
- Reads:
  - Combinational, zero latency.
  - rd_data[k] = reg[rd_addr[k]].
  - If ZERO_REG=1 and the address is 0, the read returns 0.
  - If BYPASS=1 and a write that takes effect this cycle targets the address, the read returns that write data, resolved with port-1 priority. Register 0 is never bypassed when ZERO_REG=1.
- Writes:
  - Take effect on the rising clk edge when the enable is high.
  - If we0 and we1 are both high and wa0==wa1, only wd1 is stored.
  - If the addresses differ, both writes are stored.
  - If ZERO_REG=1, writes to address 0 are discarded.
- Dump FSM, states IDLE, SEND, DONE:
  - IDLE: on dump_start=1, move to SEND. Set idx=0 and capture dump_data=reg[0] (post-ZERO_REG value) at the same edge.
  - SEND: dump_valid=1, dump_addr=idx, dump_busy=1.
    - Beat accepted when dump_valid && dump_ready at a clock edge.
    - On accept with idx<DEPTH-1: increment idx and capture reg[idx+1] at that edge.
    - On accept with idx==DEPTH-1: move to DONE.
    - Without accept, dump_addr and dump_data hold stable even if that register is written.
    - A write to a not-yet-sent index lands before its capture, so the new value is dumped.
    - Same-edge write and capture of the same index captures the pre-write value.
  - DONE: dump_done=1 and dump_busy=1 for exactly one cycle, dump_valid=0, then IDLE.
  - dump_start is ignored outside IDLE.
  - Reads and writes continue to operate normally during a dump.
  - Reset mid-dump aborts it: no dump_done pulse.
- The dump engine never stalls or blocks the datapath ports.

Test Plan:
- Reset then read all addresses on every port -> all rd_data=0. Write 0xDEADBEEF to reg 5 via port 0 -> next cycle rd_addr=5 reads 0xDEADBEEF on every port.
- ZERO_REG=1: we1=1, wa1=0, wd1=0x12345678 -> rd_data for address 0 stays 0. Same with BYPASS=1 -> still 0.
- Collision: we0=we1=1, wa0=wa1=7, wd0=0x1111, wd1=0x2222 -> reg 7=0x2222. With wa0=3 and wa1=4 -> reg 3=0x1111, reg 4=0x2222.
- BYPASS=1: we0=1, wa0=9, wd0=0xA5A5, rd_addr[0]=9 in the same cycle -> rd_data[0]=0xA5A5 before the edge. With BYPASS=0 -> old value 0.
- Dump with reg k preloaded to k*0x10 and dump_ready toggling 1,0,1,0 -> 32 beats, addr 0..31, data k*0x10. Data stable during ready=0 stalls. dump_done pulses once. dump_start during the dump is ignored.
- Assert rst while dump_addr=12 -> immediately dump_valid=0, dump_busy=0, no dump_done, all registers 0.

Source files
------------

// File: rtl/mips_regfile_mp.sv
// Multi-port register file for the MIPS datapath: N combinational read ports, two prioritised
// write ports (port 1 wins on collision) and a handshaked engine that streams out every register.
module mips_regfile_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        wa0,
  input  logic [DATA_W-1:0]        wd0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        wa1,
  input  logic [DATA_W-1:0]        wd1,
  input  logic                     dump_start,
  output logic                     dump_valid,
  input  logic                     dump_ready,
  output logic [ADDR_W-1:0]        dump_addr,
  output logic [DATA_W-1:0]        dump_data,
  output logic                     dump_busy,
  output logic                     dump_done
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StSend, StDone} dump_st_e;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  dump_st_e          state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] dump_data_q, dump_data_d;
  logic              wr0_ok, wr1_ok;

  // Writes to the hardwired-zero register are dropped before they reach the array.
  assign wr0_ok = we0 && !((ZERO_REG != 0) && (wa0 == '0));
  assign wr1_ok = we1 && !((ZERO_REG != 0) && (wa1 == '0));

  always_comb begin
    mem_d = mem_q;
    if (wr0_ok) mem_d[wa0] = wd0;
    if (wr1_ok) mem_d[wa1] = wd1;
  end

  always_comb begin
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rv;
    rd_data = '0;
    ra      = '0;
    rv      = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      ra = rd_addr[k*ADDR_W +: ADDR_W];
      rv = mem_q[ra];
      if (BYPASS != 0) begin
        if (wr0_ok && (wa0 == ra)) rv = wd0;
        if (wr1_ok && (wa1 == ra)) rv = wd1;
      end
      if ((ZERO_REG != 0) && (ra == '0)) rv = '0;
      rd_data[k*DATA_W +: DATA_W] = rv;
    end
  end

  // Captures read the pre-edge array, so a same-edge write to the captured index is not seen.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    dump_data_d = dump_data_q;
    unique case (state_q)
      StIdle: begin
        if (dump_start) begin
          state_d     = StSend;
          idx_d       = '0;
          dump_data_d = mem_q[0];
        end
      end
      StSend: begin
        if (dump_ready) begin
          if (idx_q == LastIdx) begin
            state_d = StDone;
          end else begin
            idx_d       = idx_q + ADDR_W'(1);
            dump_data_d = mem_q[idx_q + ADDR_W'(1)];
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q       <= '{default: '0};
      state_q     <= StIdle;
      idx_q       <= '0;
      dump_data_q <= '0;
    end else begin
      mem_q       <= mem_d;
      state_q     <= state_d;
      idx_q       <= idx_d;
      dump_data_q <= dump_data_d;
    end
  end

  assign dump_valid = (state_q == StSend);
  assign dump_busy  = (state_q != StIdle);
  assign dump_done  = (state_q == StDone);
  assign dump_addr  = idx_q;
  assign dump_data  = dump_data_q;

endmodule

// File: tb/tb_mips_regfile_mp.sv
// Randomised bench for mips_regfile_mp: a plain-array reference model checks a no-bypass and a
// bypass instance side by side, plus directed collision, zero-register, dump and reset cases.
module tb_mips_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data_a, rd_data_b;
  logic        we0, we1;
  logic [4:0]  wa0, wa1;
  logic [31:0] wd0, wd1;
  logic        dump_start, dump_ready;
  logic        dv_a, dv_b, busy_a, busy_b, done_a, done_b;
  logic [4:0]  daddr_a, daddr_b;
  logic [31:0] ddata_a, ddata_b;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] mem [32];

  always #5 clk = ~clk;

  mips_regfile_mp #(.BYPASS(0)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_a),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .dump_start(dump_start), .dump_valid(dv_a), .dump_ready(dump_ready),
    .dump_addr(daddr_a), .dump_data(ddata_a), .dump_busy(busy_a), .dump_done(done_a)
  );

  mips_regfile_mp #(.BYPASS(1)) dut_b (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .dump_start(dump_start), .dump_valid(dv_b), .dump_ready(dump_ready),
    .dump_addr(daddr_b), .dump_data(ddata_b), .dump_busy(busy_b), .dump_done(done_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
    end
  endtask

  // Architectural view: register 0 is zero; with bypass a pending write shows, port 1 winning.
  function automatic logic [31:0] model_rd(input logic [4:0] a, input bit byp);
    if (a == 0) return 32'h0;
    if (byp && we1 && wa1 == a) return wd1;
    if (byp && we0 && wa0 == a) return wd0;
    return mem[a];
  endfunction

  task automatic cycle();
    @(posedge clk);
    if (!rst) begin
      if (we0 && wa0 != 0) mem[wa0] = wd0;
      if (we1 && wa1 != 0) mem[wa1] = wd1;
    end
    @(negedge clk);
  endtask

  task automatic check_reads(input string tag);
    #1;
    for (int k = 0; k < 2; k++) begin
      check({tag, "_a"}, rd_data_a[k*32 +: 32], model_rd(rd_addr[k*5 +: 5], 1'b0));
      check({tag, "_b"}, rd_data_b[k*32 +: 32], model_rd(rd_addr[k*5 +: 5], 1'b1));
    end
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
  endtask

  initial begin
    int   beat, done_cnt, cnt;
    bit   finished, acc, rdy;
    rst = 1'b1; rd_addr = '0; we0 = 0; we1 = 0; wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0;
    dump_start = 0; dump_ready = 0;
    foreach (mem[i]) mem[i] = '0;
    #12;
    check("rst_valid", {31'b0, dv_a}, 0);
    check("rst_busy", {31'b0, busy_a}, 0);
    check("rst_done", {31'b0, done_a}, 0);
    check("rst_daddr", {27'b0, daddr_a}, 0);
    check("rst_ddata", ddata_a, 0);
    @(negedge clk); rst = 1'b0;

    for (int a = 0; a < 32; a++) begin
      set_rd(a[4:0], 5'(31 - a));
      #1;
      check("rst_rd0", rd_data_a[31:0], 0);
      check("rst_rd1", rd_data_b[63:32], 0);
    end

    we0 = 1; wa0 = 5; wd0 = 32'hDEADBEEF; cycle(); we0 = 0;
    set_rd(5, 5); #1;
    check("wr5_p0", rd_data_a[31:0], 32'hDEADBEEF);
    check("wr5_p1", rd_data_a[63:32], 32'hDEADBEEF);

    we1 = 1; wa1 = 0; wd1 = 32'h12345678; set_rd(0, 0); #1;
    check("zero_byp_b", rd_data_b[31:0], 0);
    check("zero_nobyp_a", rd_data_a[63:32], 0);
    cycle(); we1 = 0; #1;
    check("zero_after_a", rd_data_a[31:0], 0);
    check("zero_after_b", rd_data_b[63:32], 0);

    we0 = 1; we1 = 1; wa0 = 7; wa1 = 7; wd0 = 32'h1111; wd1 = 32'h2222; cycle();
    wa0 = 3; wa1 = 4; cycle(); we0 = 0; we1 = 0;
    set_rd(7, 3); #1;
    check("coll_r7", rd_data_a[31:0], 32'h2222);
    check("coll_r3", rd_data_a[63:32], 32'h1111);
    set_rd(4, 4); #1;
    check("coll_r4", rd_data_a[31:0], 32'h2222);

    we0 = 1; wa0 = 9; wd0 = 32'hA5A5; set_rd(9, 9); #1;
    check("byp_on", rd_data_b[31:0], 32'hA5A5);
    check("byp_off", rd_data_a[31:0], 0);
    cycle(); we0 = 0;

    for (int i = 0; i < 400; i++) begin
      we0 = 1'($urandom); we1 = 1'($urandom);
      wa0 = 5'($urandom); wa1 = ($urandom_range(0, 3) == 0) ? wa0 : 5'($urandom);
      wd0 = $urandom; wd1 = $urandom;
      set_rd(($urandom_range(0, 2) == 0) ? wa0 : 5'($urandom),
             ($urandom_range(0, 2) == 0) ? wa1 : 5'($urandom));
      check_reads("rand");
      cycle();
    end
    we0 = 0; we1 = 0;

    // Preload reg k with k*0x10, two registers per cycle.
    for (int k = 0; k < 32; k += 2) begin
      we0 = 1; we1 = 1; wa0 = 5'(k); wa1 = 5'(k + 1);
      wd0 = 32'(k * 16); wd1 = 32'((k + 1) * 16); cycle();
    end
    we0 = 0; we1 = 0;

    dump_start = 1; dump_ready = 0; cycle(); dump_start = 0;
    beat = 0; done_cnt = 0; finished = 0; rdy = 1;
    for (int c = 0; c < 200 && !finished; c++) begin
      #1;
      acc = 0;
      if (dv_a) begin
        check("dump_addr", {27'b0, daddr_a}, 32'(beat));
        check("dump_data", ddata_a, 32'(beat * 16));
        check("dump_data_b", ddata_b, 32'(beat * 16));
        check("dump_busy", {31'b0, busy_a}, 1);
        dump_ready = rdy; acc = rdy;
        dump_start = (c % 5 == 2);
        // During a stall, overwrite the register being offered; the held beat must not change.
        we0 = !rdy && beat != 0; wa0 = 5'(beat); wd0 = $urandom;
        rdy = !rdy;
      end else begin
        dump_start = 0; we0 = 0;
        check("dump_done", {31'b0, done_a}, 1);
        check("dump_done_busy", {31'b0, busy_a}, 1);
        done_cnt++; finished = 1;
      end
      cycle();
      if (acc) beat++;
    end
    we0 = 0; dump_ready = 0; #1;
    check("dump_beats", 32'(beat), 32);
    check("dump_finished", {31'b0, finished}, 1);
    check("done_pulses", 32'(done_cnt), 1);
    check("done_low", {31'b0, done_a}, 0);
    check("idle_busy", {31'b0, busy_a}, 0);
    check("idle_b", {31'b0, busy_b}, 0);
    cycle();
    check("no_restart", {31'b0, busy_a}, 0);

    dump_start = 1; dump_ready = 1; cycle(); dump_start = 0;
    cnt = 0;
    while (!(dv_a && daddr_a == 12) && cnt < 100) begin cycle(); cnt++; end
    check("reach_addr12", {31'b0, dv_a && daddr_a == 12}, 1);
    rst = 1; #1;
    foreach (mem[i]) mem[i] = '0;
    check("mid_rst_valid", {31'b0, dv_a}, 0);
    check("mid_rst_busy", {31'b0, busy_a}, 0);
    check("mid_rst_done", {31'b0, done_a}, 0);
    for (int a = 0; a < 32; a += 4) begin
      set_rd(a[4:0], 5'(a + 3)); #1;
      check("mid_rst_rd", rd_data_a[31:0], 0);
      check("mid_rst_rd_b", rd_data_b[63:32], 0);
    end
    @(negedge clk); rst = 0;
    for (int i = 0; i < 4; i++) begin
      cycle(); #1;
      check("post_rst_done", {31'b0, done_a}, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
